select32_seq: RTL

- Sequential 32-bit bit-select unit, the inverse of the team's popcount: given word I and rank K, returns the bit position of the K-th set bit (0-based, counted from bit 0), plus the total population count.
- Builds the pair-sum count tree once, then descends it one level per cycle.
- Sits beside the popcount block in the bit-manipulation datapath.
- Uses valid/ready handshakes on both sides.

---
 rtl/select32_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/select32_seq.sv
// rtl/select32_seq.sv - sequential 32-bit select: position of the K-th set bit plus popcount
//
// Builds a pair-sum count tree over the latched word in one cycle, then walks
// it from the 16-bit halves down to single bits, one level per cycle.
//
// Optional build macro: SELECT32_MSB_FIRST_EN (rank counted from bit 31 down).
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   IN_VALID   request valid            IN_READY   ready for a request (IDLE)
//   I          32-bit word to search    K          rank of the wanted set bit
//   OUT_VALID  result valid             OUT_READY  consumer takes the result
//   POS        bit index of the K-th set bit (0 when FOUND=0)
//   FOUND      K < popcount(I)          CNT        popcount(I), 0..32

module select32_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] I,
  input  logic [4:0]  K,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [4:0]  POS,
  output logic        FOUND,
  output logic [5:0]  CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUM  = 2'd1,
    S_DESC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_word;
  logic [4:0]  r_rank;
  logic [4:0]  r_r;
  logic [4:0]  r_p;
  logic [2:0]  r_lvl;

  logic [1:0]  r_c1 [16];
  logic [2:0]  r_c2 [8];
  logic [3:0]  r_c3 [4];
  logic [4:0]  r_c4 [2];

  logic [1:0]  w_c1 [16];
  logic [2:0]  w_c2 [8];
  logic [3:0]  w_c3 [4];
  logic [4:0]  w_c4 [2];
  logic [5:0]  w_total;
  logic        w_miss;

  logic [4:0]  w_idx;
  logic [4:0]  w_cnt;
  logic [4:0]  w_step;
  logic        w_take;
  logic [4:0]  w_r_next;
  logic [4:0]  w_p_next;

  assign IN_READY = (r_state == S_IDLE);

  // Count tree over the latched word; registered on the SUM cycle.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_c1[i] = {1'b0, r_word[2*i]} + {1'b0, r_word[2*i+1]};
    end
    for (int i = 0; i < 8; i++) begin
      w_c2[i] = {1'b0, w_c1[2*i]} + {1'b0, w_c1[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      w_c3[i] = {1'b0, w_c2[2*i]} + {1'b0, w_c2[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      w_c4[i] = {1'b0, w_c3[2*i]} + {1'b0, w_c3[2*i+1]};
    end
    w_total = {1'b0, w_c4[0]} + {1'b0, w_c4[1]};
  end

  assign w_miss = ({1'b0, r_rank} >= w_total);

  // Child-count lookup for the current level. The block under inspection is
  // aligned to 2^(L+1), so its low child sits at index p>>L and the high child
  // at the next (odd) index.
  always_comb begin
    w_idx = 5'd0;
    w_cnt = 5'd0;
`ifdef SELECT32_MSB_FIRST_EN
    w_idx = (r_p >> r_lvl) | 5'd1;
`else
    w_idx = r_p >> r_lvl;
`endif
    case (r_lvl)
      3'd4:    w_cnt = r_c4[w_idx[0]];
      3'd3:    w_cnt = {1'b0, r_c3[w_idx[1:0]]};
      3'd2:    w_cnt = {2'b0, r_c2[w_idx[2:0]]};
      3'd1:    w_cnt = {3'b0, r_c1[w_idx[3:0]]};
      default: w_cnt = {4'b0, r_word[w_idx]};
    endcase
  end

  // w_take: the wanted bit lies beyond the inspected child, so its count is
  // consumed from the remaining rank. Subtraction only happens when r >= cnt.
  always_comb begin
    w_step   = 5'd1 << r_lvl;
    w_take   = (r_r >= w_cnt);
    w_r_next = r_r;
    w_p_next = r_p;
    if (w_take) begin
      w_r_next = r_r - w_cnt;
    end
`ifdef SELECT32_MSB_FIRST_EN
    if (!w_take) begin
      w_p_next = r_p + w_step;
    end
`else
    if (w_take) begin
      w_p_next = r_p + w_step;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (IN_VALID) w_next = S_SUM;
      S_SUM:  w_next = w_miss ? S_DONE : S_DESC;
      S_DESC: if (r_lvl == 3'd0) w_next = S_DONE;
      S_DONE: if (OUT_READY) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_word    <= 32'd0;
      r_rank    <= 5'd0;
      r_r       <= 5'd0;
      r_p       <= 5'd0;
      r_lvl     <= 3'd0;
      OUT_VALID <= 1'b0;
      POS       <= 5'd0;
      FOUND     <= 1'b0;
      CNT       <= 6'd0;
      for (int i = 0; i < 16; i++) r_c1[i] <= 2'd0;
      for (int i = 0; i < 8; i++)  r_c2[i] <= 3'd0;
      for (int i = 0; i < 4; i++)  r_c3[i] <= 4'd0;
      for (int i = 0; i < 2; i++)  r_c4[i] <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_word <= I;
            r_rank <= K;
          end
        end
        S_SUM: begin
          for (int i = 0; i < 16; i++) r_c1[i] <= w_c1[i];
          for (int i = 0; i < 8; i++)  r_c2[i] <= w_c2[i];
          for (int i = 0; i < 4; i++)  r_c3[i] <= w_c3[i];
          for (int i = 0; i < 2; i++)  r_c4[i] <= w_c4[i];
          CNT <= w_total;
          r_r <= r_rank;
          r_p <= 5'd0;
          if (w_miss) begin
            FOUND     <= 1'b0;
            POS       <= 5'd0;
            OUT_VALID <= 1'b1;
          end else begin
            FOUND <= 1'b1;
            r_lvl <= 3'd4;
          end
        end
        S_DESC: begin
          r_r   <= w_r_next;
          r_p   <= w_p_next;
          r_lvl <= r_lvl - 3'd1;
          if (r_lvl == 3'd0) begin
            POS       <= w_p_next;
            OUT_VALID <= 1'b1;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
